// File: rtl/alu_a_fwd_unit.sv
//==============================================================================
// Module   : alu_a_fwd_unit
// Purpose  : ALU operand-A forwarding and load-use hazard detection for the
//            16-bit five-stage core. Optional WB-slot forwarding: ALU_A_WB_FWD_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_a_fwd_unit #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  id_src_a,
  input  logic              id_src_a_vld,
  input  logic [REG_W-1:0]  id_dst,
  input  logic              id_dst_we,
  input  logic              id_is_load,
  input  logic              pipe_stall,
  input  logic              ex_flush,
  input  logic [DATA_W-1:0] mem_alu_data,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ALU_A_FOWD_en,
  output logic [DATA_W-1:0] data_FOWD,
  output logic              load_use_stall
);

`ifdef ALU_A_WB_FWD_EN
  localparam logic c_WB_FWD = 1'b1;
`else
  localparam logic c_WB_FWD = 1'b0;
`endif

  // EX slot
  logic             r_ex_vld;
  logic [REG_W-1:0] r_ex_dst;
  logic             r_ex_we;
  logic             r_ex_ld;
  logic [REG_W-1:0] r_ex_src_a;
  logic             r_ex_src_a_vld;
  // MEM slot
  logic             r_mem_vld;
  logic [REG_W-1:0] r_mem_dst;
  logic             r_mem_we;
  logic             r_mem_ld;
  // WB slot (its load flag is never consulted, so it is not kept)
  logic             r_wb_vld;
  logic [REG_W-1:0] r_wb_dst;
  logic             r_wb_we;

  logic w_ex_lu;
  logic w_mem_lu;
  logic w_mem_hit;
  logic w_wb_hit;
  logic w_bubble;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ex_vld       <= 1'b0;
      r_ex_dst       <= '0;
      r_ex_we        <= 1'b0;
      r_ex_ld        <= 1'b0;
      r_ex_src_a     <= '0;
      r_ex_src_a_vld <= 1'b0;
      r_mem_vld      <= 1'b0;
      r_mem_dst      <= '0;
      r_mem_we       <= 1'b0;
      r_mem_ld       <= 1'b0;
      r_wb_vld       <= 1'b0;
      r_wb_dst       <= '0;
      r_wb_we        <= 1'b0;
    end else if (!pipe_stall) begin
      r_wb_vld  <= r_mem_vld;
      r_wb_dst  <= r_mem_dst;
      r_wb_we   <= r_mem_we;
      r_mem_vld <= r_ex_vld;
      r_mem_dst <= r_ex_dst;
      r_mem_we  <= r_ex_we;
      r_mem_ld  <= r_ex_ld;
      if (w_bubble) begin
        r_ex_vld       <= 1'b0;
        r_ex_dst       <= '0;
        r_ex_we        <= 1'b0;
        r_ex_ld        <= 1'b0;
        r_ex_src_a     <= '0;
        r_ex_src_a_vld <= 1'b0;
      end else begin
        r_ex_vld       <= 1'b1;
        r_ex_dst       <= id_dst;
        r_ex_we        <= id_dst_we;
        r_ex_ld        <= id_is_load;
        r_ex_src_a     <= id_src_a;
        r_ex_src_a_vld <= id_src_a_vld;
      end
    end
  end

  // Without WB forwarding a load still in MEM is too early for the consumer,
  // so the stall is stretched by one more cycle.
  assign w_ex_lu  = id_src_a_vld & r_ex_vld & r_ex_we & r_ex_ld &
                    (r_ex_dst == id_src_a);
  assign w_mem_lu = ~c_WB_FWD & id_src_a_vld & r_mem_vld & r_mem_we & r_mem_ld &
                    (r_mem_dst == id_src_a);
  assign load_use_stall = w_ex_lu | w_mem_lu;
  assign w_bubble       = load_use_stall | ex_flush;

  // A load sitting in MEM has no data yet, so it is never a MEM hit.
  assign w_mem_hit = r_ex_src_a_vld & r_mem_vld & r_mem_we & ~r_mem_ld &
                     (r_mem_dst == r_ex_src_a);
  assign w_wb_hit  = c_WB_FWD & r_ex_src_a_vld & r_wb_vld & r_wb_we &
                     (r_wb_dst == r_ex_src_a);

  always_comb begin
    ALU_A_FOWD_en = 1'b0;
    data_FOWD     = '0;
    if (w_mem_hit) begin
      ALU_A_FOWD_en = 1'b1;
      data_FOWD     = mem_alu_data;
    end else if (w_wb_hit) begin
      ALU_A_FOWD_en = 1'b1;
      data_FOWD     = wb_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_a_fwd_unit.sv
//==============================================================================
// Module   : tb_alu_a_fwd_unit
// Purpose  : Directed vector bench for alu_a_fwd_unit (honours ALU_A_WB_FWD_EN).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_a_fwd_unit;

`ifdef ALU_A_WB_FWD_EN
  localparam bit c_WB = 1'b1;
`else
  localparam bit c_WB = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  id_src_a;
  logic        id_src_a_vld;
  logic [3:0]  id_dst;
  logic        id_dst_we;
  logic        id_is_load;
  logic        pipe_stall;
  logic        ex_flush;
  logic [15:0] mem_alu_data;
  logic [15:0] wb_data;
  logic        ALU_A_FOWD_en;
  logic [15:0] data_FOWD;
  logic        load_use_stall;

  int total;
  int bad;

  alu_a_fwd_unit #(.DATA_W(16), .REG_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_src_a       (id_src_a),
    .id_src_a_vld   (id_src_a_vld),
    .id_dst         (id_dst),
    .id_dst_we      (id_dst_we),
    .id_is_load     (id_is_load),
    .pipe_stall     (pipe_stall),
    .ex_flush       (ex_flush),
    .mem_alu_data   (mem_alu_data),
    .wb_data        (wb_data),
    .ALU_A_FOWD_en  (ALU_A_FOWD_en),
    .data_FOWD      (data_FOWD),
    .load_use_stall (load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rs;
    logic [3:0]  src;
    logic        sv;
    logic [3:0]  dst;
    logic        we;
    logic        ld;
    logic        ps;
    logic        fl;
    logic [15:0] md;
    logic [15:0] wd;
    logic        e_en;
    logic [15:0] e_dat;
    logic        e_st;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic rs, logic [3:0] src, logic sv, logic [3:0] dst,
                              logic we, logic ld, logic ps, logic fl,
                              logic [15:0] md, logic [15:0] wd,
                              logic e_en, logic [15:0] e_dat, logic e_st);
    vec_t v;
    v.rs = rs; v.src = src; v.sv = sv; v.dst = dst; v.we = we; v.ld = ld;
    v.ps = ps; v.fl = fl; v.md = md; v.wd = wd;
    v.e_en = e_en; v.e_dat = e_dat; v.e_st = e_st;
    return v;
  endfunction

  task automatic check(input string nm, input logic e_en, input logic [15:0] e_dat,
                       input logic e_st);
    total++;
    if (ALU_A_FOWD_en !== e_en || data_FOWD !== e_dat || load_use_stall !== e_st) begin
      bad++;
      $display("FAIL %s: got en=%b data=%h stall=%b, want en=%b data=%h stall=%b",
               nm, ALU_A_FOWD_en, data_FOWD, load_use_stall, e_en, e_dat, e_st);
    end
  endtask

  task automatic drive(input logic [3:0] src, input logic sv, input logic [3:0] dst,
                       input logic we, input logic ld, input logic ps, input logic fl,
                       input logic [15:0] md, input logic [15:0] wd);
    id_src_a = src; id_src_a_vld = sv; id_dst = dst; id_dst_we = we;
    id_is_load = ld; pipe_stall = ps; ex_flush = fl; mem_alu_data = md; wb_data = wd;
  endtask

  // Entered and left at posedge+1
  task automatic do_reset();
    drive(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    rst = 1'b0;
    #1;
    check("reset", 1'b0, 16'h0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic step(input logic [3:0] src, input logic sv, input logic [3:0] dst,
                      input logic we, input logic ld, input logic [15:0] md,
                      input logic [15:0] wd);
    drive(src, sv, dst, we, ld, 1'b0, 1'b0, md, wd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    drive(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Group 1: back-to-back, distance-2, MEM priority, load-use
    tv.push_back(mk(1, 4'd2, 1, 4'd1,  1, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0));
    tv.push_back(mk(0, 4'd1, 1, 4'd4,  1, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0));
    tv.push_back(mk(0, 4'd7, 1, 4'd6,  1, 0, 0, 0, 16'h1234, 16'h0000, 1, 16'h1234, 0));
    tv.push_back(mk(0, 4'd4, 1, 4'd6,  1, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0));
    tv.push_back(mk(0, 4'd6, 1, 4'd6,  1, 0, 0, 0, 16'h0001, 16'hBEEF,
                    c_WB, c_WB ? 16'hBEEF : 16'h0000, 0));
    tv.push_back(mk(0, 4'd3, 1, 4'd1,  1, 1, 0, 0, 16'h0001, 16'h0002, 1, 16'h0001, 0));
    tv.push_back(mk(0, 4'd1, 1, 4'd4,  1, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1));
    tv.push_back(mk(0, 4'd1, 1, 4'd4,  1, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, !c_WB));
    if (c_WB) begin
      tv.push_back(mk(0, 4'd9, 1, 4'd10, 1, 0, 0, 0, 16'h0000, 16'h5A5A, 1, 16'h5A5A, 0));
    end else begin
      tv.push_back(mk(0, 4'd1, 1, 4'd4,  1, 0, 0, 0, 16'h0000, 16'h5A5A, 0, 16'h0000, 0));
      tv.push_back(mk(0, 4'd9, 1, 4'd10, 1, 0, 0, 0, 16'h0000, 16'h5A5A, 0, 16'h0000, 0));
    end

    // Group 2: pipe_stall freezes a pending load-use hazard plus a MEM hit
    tv.push_back(mk(1, 4'd0, 0, 4'd3,  1, 0, 0, 0, 16'h7777, 16'h0000, 0, 16'h0000, 0));
    tv.push_back(mk(0, 4'd3, 1, 4'd1,  1, 1, 0, 0, 16'h7777, 16'h0000, 0, 16'h0000, 0));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(0, 4'd1, 1, 4'd4, 1, 0, 1, 0, 16'h7777, 16'h0000, 1, 16'h7777, 1));
    tv.push_back(mk(0, 4'd1, 1, 4'd4,  1, 0, 0, 0, 16'h7777, 16'h0000, 1, 16'h7777, 1));
    tv.push_back(mk(0, 4'd1, 1, 4'd4,  1, 0, 0, 0, 16'h7777, 16'h5A5A, 0, 16'h0000, !c_WB));

    // Group 3: flush of a dependent consumer, then flush coinciding with load-use
    tv.push_back(mk(1, 4'd0, 0, 4'd5,  1, 0, 0, 0, 16'h1111, 16'h0000, 0, 16'h0000, 0));
    tv.push_back(mk(0, 4'd5, 1, 4'd4,  1, 0, 0, 1, 16'h1111, 16'h0000, 0, 16'h0000, 0));
    tv.push_back(mk(0, 4'd9, 1, 4'd10, 1, 0, 0, 0, 16'h1111, 16'h0000, 0, 16'h0000, 0));
    tv.push_back(mk(0, 4'd0, 0, 4'd2,  1, 1, 0, 0, 16'h1111, 16'h0000, 0, 16'h0000, 0));
    tv.push_back(mk(0, 4'd2, 1, 4'd4,  1, 0, 0, 1, 16'h1111, 16'h0000, 0, 16'h0000, 1));
    tv.push_back(mk(0, 4'd2, 1, 4'd4,  1, 0, 0, 0, 16'h1111, 16'h0000, 0, 16'h0000, !c_WB));

    @(posedge clk);
    #1;
    foreach (tv[i]) begin
      if (tv[i].rs) do_reset();
      drive(tv[i].src, tv[i].sv, tv[i].dst, tv[i].we, tv[i].ld, tv[i].ps, tv[i].fl,
            tv[i].md, tv[i].wd);
      #1;
      check($sformatf("vec%0d", i), tv[i].e_en, tv[i].e_dat, tv[i].e_st);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-stream with a MEM hit and a load-use stall active
    do_reset();
    step(4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 16'h0, 16'h0);
    step(4'd3, 1'b1, 4'd1, 1'b1, 1'b1, 16'h0, 16'h0);
    drive(4'd1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 16'h9999, 16'h0);
    #1;
    check("pre_async_rst", 1'b1, 16'h9999, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst", 1'b0, 16'h0000, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check("after_rst_release", 1'b0, 16'h0000, 1'b0);
    @(posedge clk);
    #1;
    step(4'd0, 1'b0, 4'd2, 1'b1, 1'b0, 16'h0, 16'h0);
    drive(4'd2, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk);
    #1;
    drive(4'd9, 1'b1, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 16'h4321, 16'h0);
    #1;
    check("post_rst_advance", 1'b1, 16'h4321, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_a_fwd_unit.md
# alu_a_fwd_unit

Operand-A forwarding and load-use hazard unit for the 16-bit five-stage core. It tracks the destination registers of instructions in the EX, MEM and WB stages and compares them against the source-A register of the instruction entering EX. When there is a match it drives the forward-enable and forward-data inputs of the ALU operand-A select stage. It also raises a one-cycle stall when a load result is needed by the next instruction.

## Interface
Parameters:
- DATA_W, 16, datapath width (matches DATA_BUS)
- REG_W, 4, register-id width (R0–R7, T, SP, IH, RA encoded 0–11)

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- id_src_a  in  REG_W  source-A register id of the instruction in ID
- id_src_a_vld  in  1  instruction in ID reads a register for operand A
- id_dst  in  REG_W  destination register id of the instruction in ID
- id_dst_we  in  1  instruction in ID writes id_dst
- id_is_load  in  1  instruction in ID is a memory load
- pipe_stall  in  1  external freeze (memory conflict); holds all slots
- ex_flush  in  1  branch taken; inserts a bubble into EX at the next edge
- mem_alu_data  in  DATA_W  ALU result currently in the MEM stage
- wb_data  in  DATA_W  write-back data currently in the WB stage
- ALU_A_FOWD_en  out  1  forward select for ALU operand A (EX stage)
- data_FOWD  out  DATA_W  forwarded operand-A value
- load_use_stall  out  1  hold PC and IF/ID, bubble into EX

## Operation
- Three slots, EX, MEM and WB, each holding {vld, dst, we, is_load}. EX also holds {src_a, src_a_vld}.
- Advance rule, when pipe_stall=0: ID→EX, EX→MEM, MEM→WB.
  - If load_use_stall=1 or ex_flush=1, the EX slot loads a bubble: all fields 0.
- When pipe_stall=1, all slots hold. pipe_stall has priority over ex_flush and load_use_stall.
- Hazard detection (combinational, ID vs EX):
  - load_use_stall = id_src_a_vld & EX.vld & EX.we & EX.is_load & (EX.dst==id_src_a).
- Forward selection (combinational, EX vs MEM/WB), in priority order:
  1. MEM hit: MEM.vld & MEM.we & !MEM.is_load & MEM.dst==EX.src_a → ALU_A_FOWD_en=1, data_FOWD=mem_alu_data.
  2. WB hit: WB.vld & WB.we & WB.dst==EX.src_a → ALU_A_FOWD_en=1, data_FOWD=wb_data.
  3. Otherwise ALU_A_FOWD_en=0 and data_FOWD=0.
- Forwarding requires EX.src_a_vld=1. If it is 0, no forwarding occurs.
- A MEM-slot load that matches EX.src_a is unreachable, because the stall prevents it. The unit must not forward mem_alu_data in that case.

## Timing
- Reset (rst=0, asynchronous): all slots cleared, ALU_A_FOWD_en=0, data_FOWD=0, load_use_stall=0. This applies mid-operation as well; no partial state survives.
- First edge after reset release: normal advance.
- Forward outputs are valid in the same cycle the consumer is in EX, with zero added latency. The path is combinational from registered slots plus mem_alu_data/wb_data.
- load_use_stall is asserted for exactly one cycle per load-use pair.
  - After that edge the load moves to MEM, the EX slot becomes a bubble and the stall drops.
  - The consumer then forwards from WB one cycle later.
- Simultaneous load_use_stall and ex_flush: the bubble is inserted once; the flush wins trivially.
- pipe_stall during load_use_stall: the stall stays asserted until an edge with pipe_stall=0.

## Configuration
- Macro: ALU_A_WB_FWD_EN.
- Defined: WB-slot forwarding (priority 2) is active, as described above.
- Undefined: the WB slot is still tracked, but the WB hit is never taken.
  - The register file must then be write-first in the same cycle.
  - load_use_stall is extended to two cycles: it also asserts when MEM.is_load & MEM.dst==id_src_a.

## Test plan
- Back-to-back ALU ops, ADDU R1←R2+R3 then ADDU R4←R1+R5 with mem_alu_data=0x1234 → in the consumer's EX cycle ALU_A_FOWD_en=1, data_FOWD=0x1234.
- Distance-2 dependency (one unrelated instruction between) with wb_data=0xBEEF → ALU_A_FOWD_en=1, data_FOWD=0xBEEF.
- Same dst in both MEM (0x0001) and WB (0x0002) → data_FOWD=0x0001 (MEM priority).
- LW R1 then ADDU R4←R1+R5:
  - load_use_stall=1 for exactly 1 cycle, then a bubble in EX.
  - The consumer gets wb_data=0x5A5A via forwarding.
  - Without ALU_A_WB_FWD_EN the stall lasts 2 cycles and ALU_A_FOWD_en stays 0.
- pipe_stall=1 for 3 cycles during a pending hazard → slots frozen and outputs constant. ex_flush with a dependent consumer → bubble, no forward.
- rst pulled low mid-stream with a hit active → all outputs 0 immediately, with no clock edge required.
